// File: rtl/crack_sched_pkg.sv
// Shared types for the RC4 key-space scheduler.
// Provides the FSM state enum, the default key width and the key type.
package crack_sched_pkg;

   localparam int CS_KEY_W = 24;

   typedef logic [CS_KEY_W-1:0] key_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_LAUNCH,
      S_RUN,
      S_ABORT,
      S_DRAIN
   } state_t;

endpackage

// File: rtl/crack_sched_prio.sv
// Lowest-index priority encoder over the per-engine found vector.
// Ports: i_vec (request bits), o_idx (lowest set index), o_hit (any set).
module crack_sched_prio #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  i_vec,
   output logic [IW-1:0] o_idx,
   output logic          o_hit
);

   // Scan from the top down so the lowest set index is written last.
   always_comb begin
      o_idx = '0;
      o_hit = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = IW'(i);
            o_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/crack_sched.sv
// Key-space scheduler: runs NUM_ENG crack engines over interleaved key
// ranges, keeps the first valid key, aborts the rest, reports via en/rdy.
// Ports: clk, rst_n (async, active-low); en/rdy start handshake;
//   key/key_valid/found_eng/timeout result; eng_* engine array interface.
// Optional: define CRACK_SCHED_TIMEOUT_EN to enable the RUN watchdog.
module crack_sched
   import crack_sched_pkg::*;
#(
   parameter int NUM_ENG        = 2,
   parameter int KEY_W          = CS_KEY_W,
   parameter int TIMEOUT_CYCLES = 2**30,
   localparam int IW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   output logic                     rdy,
   output logic [KEY_W-1:0]         key,
   output logic                     key_valid,
   output logic [IW-1:0]            found_eng,
   output logic                     timeout,
   output logic [NUM_ENG-1:0]       eng_en,
   output logic [NUM_ENG-1:0]       eng_abort,
   output logic [NUM_ENG*KEY_W-1:0] eng_key_start,
   output logic [KEY_W-1:0]         eng_key_stride,
   input  logic [NUM_ENG-1:0]       eng_rdy,
   input  logic [NUM_ENG*KEY_W-1:0] eng_key,
   input  logic [NUM_ENG-1:0]       eng_key_valid
);

   state_t             r_state;
   state_t             w_next;
   logic [NUM_ENG-1:0] r_busy_seen;
   logic [NUM_ENG-1:0] r_done;
   logic [NUM_ENG-1:0] w_done_now;
   logic [NUM_ENG-1:0] w_found;
   logic [IW-1:0]      w_win;
   logic               w_hit;
   logic               w_all_rdy;
   logic               w_all_done;
   logic               w_to;
   logic [KEY_W-1:0]   w_win_key;
   logic [KEY_W-1:0]   r_key;
   logic               r_kv;
   logic [IW-1:0]      r_fe;
   logic               r_to;

   for (genvar g = 0; g < NUM_ENG; g++) begin : g_start
      assign eng_key_start[g*KEY_W +: KEY_W] = KEY_W'(g);
   end
   assign eng_key_stride = KEY_W'(NUM_ENG);

   // An engine only counts as done once it has been seen busy, so a
   // stale rdy right after launch is never mistaken for completion.
   assign w_all_rdy  = &eng_rdy;
   assign w_done_now = r_busy_seen & eng_rdy & ~r_done;
   assign w_all_done = &(r_done | w_done_now);
   assign w_found    = (r_state == S_RUN) ? (w_done_now & eng_key_valid)
                                          : '0;

   crack_sched_prio #(
      .N  (NUM_ENG),
      .IW (IW)
   ) u_prio (
      .i_vec (w_found),
      .o_idx (w_win),
      .o_hit (w_hit)
   );

   assign w_win_key = eng_key[int'(w_win)*KEY_W +: KEY_W];

`ifdef CRACK_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == S_LAUNCH) begin
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign w_to = (r_state == S_RUN) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign w_to = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (en) w_next = S_SYNC;
         S_SYNC:   if (w_all_rdy) w_next = S_LAUNCH;
         S_LAUNCH: w_next = S_RUN;
         S_RUN: begin
            if (w_hit)           w_next = S_ABORT;
            else if (w_all_done) w_next = S_IDLE;
            else if (w_to)       w_next = S_ABORT;
         end
         S_ABORT:  w_next = S_DRAIN;
         S_DRAIN:  if (w_all_rdy) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy_seen <= '0;
         r_done      <= '0;
         r_key       <= '0;
         r_kv        <= 1'b0;
         r_fe        <= '0;
         r_to        <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_key <= '0;
                  r_kv  <= 1'b0;
                  r_fe  <= '0;
                  r_to  <= 1'b0;
               end
            end
            S_LAUNCH: begin
               r_busy_seen <= '0;
               r_done      <= '0;
            end
            S_RUN: begin
               r_busy_seen <= r_busy_seen | ~eng_rdy;
               r_done      <= r_done | w_done_now;
               if (w_hit) begin
                  r_key <= w_win_key;
                  r_fe  <= w_win;
                  r_kv  <= 1'b1;
               end else if (w_all_done) begin
                  r_key <= '0;
                  r_kv  <= 1'b0;
               end else if (w_to) begin
                  r_to  <= 1'b1;
                  r_kv  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Engines already done (including the winner) are never aborted.
   assign rdy       = (r_state == S_IDLE);
   assign eng_en    = {NUM_ENG{r_state == S_LAUNCH}};
   assign eng_abort = (r_state == S_ABORT) ? ~r_done : '0;
   assign key       = r_key;
   assign key_valid = r_kv;
   assign found_eng = r_fe;
   assign timeout   = r_to;

endmodule

// File: tb/tb_crack_sched.sv
// Scoreboard bench for crack_sched with a behavioural engine-array model.
// Results and abort pulses are checked by a monitor against queued values.
module tb_crack_sched;
   import crack_sched_pkg::*;

   localparam int N  = 2;
   localparam int KW = 24;
   localparam int TO = 64;
`ifdef CRACK_SCHED_TIMEOUT_EN
   localparam int EXH_LAT = 40;
`else
   localparam int EXH_LAT = 100;
`endif

   typedef struct packed {
      key_t k;
      logic kv;
      logic fe;
      logic to;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          rdy;
   logic [KW-1:0] key;
   logic          key_valid;
   logic [0:0]    found_eng;
   logic          timeout;
   logic [N-1:0]  eng_en;
   logic [N-1:0]  eng_abort;
   logic [N*KW-1:0] eng_key_start;
   logic [KW-1:0] eng_key_stride;
   logic [N-1:0]  eng_rdy;
   logic [N*KW-1:0] eng_key;
   logic [N-1:0]  eng_key_valid;

   always #5 clk = ~clk;

   crack_sched #(
      .NUM_ENG        (N),
      .KEY_W          (KW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .rdy            (rdy),
      .key            (key),
      .key_valid      (key_valid),
      .found_eng      (found_eng),
      .timeout        (timeout),
      .eng_en         (eng_en),
      .eng_abort      (eng_abort),
      .eng_key_start  (eng_key_start),
      .eng_key_stride (eng_key_stride),
      .eng_rdy        (eng_rdy),
      .eng_key        (eng_key),
      .eng_key_valid  (eng_key_valid)
   );

   int           m_lat[N];
   int           m_alat[N];
   bit           m_find[N];
   key_t         m_fkey[N];
   int           m_cnt[N];
   bit           m_busy[N];
   bit           m_abt[N];
   logic [N-1:0] m_rdy;
   logic [N-1:0] m_kv;
   logic [N*KW-1:0] m_key;
   logic [N-1:0] hold_v = '0;

   assign eng_rdy       = m_rdy & ~hold_v;
   assign eng_key_valid = m_kv;
   assign eng_key       = m_key;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rdy <= '1;
         m_kv  <= '0;
         m_key <= '0;
         for (int i = 0; i < N; i++) begin
            m_busy[i] <= 1'b0;
            m_abt[i]  <= 1'b0;
            m_cnt[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (eng_en[i]) begin
               m_busy[i] <= 1'b1;
               m_abt[i]  <= 1'b0;
               m_cnt[i]  <= m_lat[i];
               m_rdy[i]  <= 1'b0;
               m_kv[i]   <= 1'b0;
            end else if (m_busy[i]) begin
               if (eng_abort[i]) begin
                  m_abt[i] <= 1'b1;
                  m_cnt[i] <= m_alat[i];
               end else if (m_cnt[i] <= 1) begin
                  m_busy[i] <= 1'b0;
                  m_rdy[i]  <= 1'b1;
                  m_kv[i]   <= m_find[i] && !m_abt[i];
                  m_key[i*KW +: KW] <= m_fkey[i];
               end else begin
                  m_cnt[i] <= m_cnt[i] - 1;
               end
            end
         end
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   res_t         q_res[$];
   logic [N-1:0] q_abt[$];
   res_t         mon_r;
   logic [N-1:0] mon_a;
   logic         prev_rdy = 1'b1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rdy && !prev_rdy) begin
            if (q_res.size() == 0) begin
               chk("unexpected_result", 64'(key_valid), 64'hx);
            end else begin
               mon_r = q_res.pop_front();
               chk("key", 64'(key), 64'(mon_r.k));
               chk("key_valid", 64'(key_valid), 64'(mon_r.kv));
               chk("found_eng", 64'(found_eng), 64'(mon_r.fe));
               chk("timeout", 64'(timeout), 64'(mon_r.to));
            end
         end
         if (|eng_abort) begin
            if (q_abt.size() == 0) begin
               chk("unexpected_abort", 64'(eng_abort), 64'h0);
            end else begin
               mon_a = q_abt.pop_front();
               chk("eng_abort", 64'(eng_abort), 64'(mon_a));
            end
         end
      end
      prev_rdy = rdy;
   end

   task automatic cfg(int e, int lat, bit fnd, key_t k, int alat);
      m_lat[e]  = lat;
      m_find[e] = fnd;
      m_fkey[e] = k;
      m_alat[e] = alat;
   endtask

   // Raise en for one cycle and return negedges until eng_en is seen.
   task automatic start(input int bound, output int c);
      @(negedge clk);
      en = 1'b1;
      c = 0;
      do begin
         @(negedge clk);
         en = 1'b0;
         c++;
      end while (!eng_en[0] && c < bound);
   endtask

   task automatic wait_rdy(string nm, int bound);
      int c = 0;
      while (!rdy && c < bound) begin
         @(negedge clk);
         c++;
      end
      chk(nm, 64'(rdy), 64'h1);
   endtask

   int c;
   int ce;
   int cd;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #3;
      chk("rst_rdy", 64'(rdy), 64'h1);
      chk("rst_key_valid", 64'(key_valid), 64'h0);
      chk("rst_key", 64'(key), 64'h0);
      chk("rst_found_eng", 64'(found_eng), 64'h0);
      chk("rst_timeout", 64'(timeout), 64'h0);
      chk("rst_eng_en", 64'(eng_en), 64'h0);
      chk("rst_eng_abort", 64'(eng_abort), 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Engine 0 finds 3C at 50 cycles, engine 1 still busy.
      cfg(0, 50, 1'b1, 24'h00003C, 1);
      cfg(1, 500, 1'b0, 24'h0, 5);
      q_res.push_back('{k: 24'h00003C, kv: 1'b1, fe: 1'b0, to: 1'b0});
      q_abt.push_back(2'b10);
      start(20, c);
      chk("launch_latency", 64'(c), 64'd2);
      ce = -1;
      cd = -1;
      c = 0;
      while (!key_valid && c < 200) begin
         @(negedge clk);
         c++;
         if (eng_rdy[0] && ce < 0) ce = c;
      end
      cd = c;
      chk("found_latency", 64'(cd), 64'(ce + 1));
      wait_rdy("found_drain", 100);

      // Engine 1 held busy: scheduler must wait in SYNC.
      hold_v = 2'b10;
      cfg(0, 30, 1'b1, 24'h000010, 1);
      cfg(1, 30, 1'b1, 24'h000011, 1);
      q_res.push_back('{k: 24'h000010, kv: 1'b1, fe: 1'b0, to: 1'b0});
      start(8, c);
      chk("sync_no_launch", 64'(eng_en), 64'h0);
      chk("sync_rdy_low", 64'(rdy), 64'h0);
      hold_v = 2'b00;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!eng_en[0] && c < 10);
      chk("sync_release_launch", 64'(c), 64'd1);
      chk("eng_key_start", 64'(eng_key_start), 64'({24'd1, 24'd0}));
      chk("eng_key_stride", 64'(eng_key_stride), 64'd2);
      wait_rdy("simul_done", 100);

      // Reset in the middle of a run.
      cfg(0, 500, 1'b0, 24'h0, 1);
      cfg(1, 500, 1'b0, 24'h0, 1);
      start(20, c);
      repeat (20) @(negedge clk);
      chk("run_rdy_low", 64'(rdy), 64'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_rdy", 64'(rdy), 64'h1);
      chk("midrst_key_valid", 64'(key_valid), 64'h0);
      chk("midrst_eng_en", 64'(eng_en), 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Exhausted run, also proves en is accepted after reset.
      cfg(0, EXH_LAT, 1'b0, 24'h0, 1);
      cfg(1, EXH_LAT, 1'b0, 24'h0, 1);
      q_res.push_back('{k: 24'h0, kv: 1'b0, fe: 1'b0, to: 1'b0});
      start(20, c);
      chk("post_rst_launch", 64'(c), 64'd2);
      ce = -1;
      c = 0;
      while (!rdy && c < 300) begin
         @(negedge clk);
         c++;
         if (&eng_rdy && ce < 0) ce = c;
      end
      chk("exhaust_rdy_latency", 64'(c), 64'(ce + 1));

`ifdef CRACK_SCHED_TIMEOUT_EN
      cfg(0, 1000, 1'b0, 24'h0, 3);
      cfg(1, 1000, 1'b0, 24'h0, 3);
      q_res.push_back('{k: 24'h0, kv: 1'b0, fe: 1'b0, to: 1'b1});
      q_abt.push_back(2'b11);
      start(20, c);
      c = 0;
      while (eng_abort == '0 && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("timeout_cycle", 64'(c), 64'(TO + 1));
      chk("timeout_flag", 64'(timeout), 64'h1);
      wait_rdy("timeout_drain", 50);
`endif

      repeat (3) @(negedge clk);
      chk("res_queue_empty", 64'(q_res.size()), 64'h0);
      chk("abt_queue_empty", 64'(q_abt.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
